// File: rtl/ysyx_220066_divider_if.sv
// EX <-> divider handshake bundle.
// master = EX stage, slave = divider.
interface ysyx_220066_divider_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            div_valid;
  logic            div_ready;
  logic            div_signed;
  logic            div_is_w;
  logic            div_rem;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, div_valid, div_signed,
    output div_is_w, div_rem,
    output dividend, divisor, out_ready,
    input  div_ready, out_valid, result
  );

  modport slave (
    input  flush, div_valid, div_signed,
    input  div_is_w, div_rem,
    input  dividend, divisor, out_ready,
    output div_ready, out_valid, result
  );
endinterface

// File: rtl/ysyx_220066_divider.sv
// RV64M radix-2 restoring divider, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish on a fast path.
module ysyx_220066_divider #(
  parameter int XLEN = 64
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_220066_divider_if.slave io
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            rsel_q, rsel_d;
  logic            w_q, w_d;

  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            a_neg, b_neg;
  logic            dz, ovf;
  logic [XLEN-1:0] fast;
  logic [XLEN:0]   t;
  logic [XLEN-1:0] t_sub;
  logic            ge;
  logic [XLEN-1:0] rem_s, quo_s;
  logic [XLEN-1:0] q_fin, r_fin, fin;

  assign io.div_ready = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.result    = result_q;

  always_comb begin
    if (io.div_is_w) begin
      a_ext = io.div_signed
            ? {{32{io.dividend[31]}}, io.dividend[31:0]}
            : {32'b0, io.dividend[31:0]};
      b_ext = io.div_signed
            ? {{32{io.divisor[31]}}, io.divisor[31:0]}
            : {32'b0, io.divisor[31:0]};
    end else begin
      a_ext = io.dividend;
      b_ext = io.divisor;
    end
    a_neg = io.div_signed & a_ext[XLEN-1];
    b_neg = io.div_signed & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    dz    = (b_ext == '0);
    ovf   = io.div_signed && (&b_ext) &&
            (io.div_is_w ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                         : (a_ext == 64'h8000_0000_0000_0000));
    if (dz) fast = io.div_rem ? a_ext : '1;
    else    fast = io.div_rem ? '0 : a_ext;
  end

  always_comb begin
    t     = {rem_q, quo_q[XLEN-1]};
    t_sub = t[XLEN-1:0] - dvs_q;
    ge    = (t >= {1'b0, dvs_q});
    rem_s = ge ? t_sub : t[XLEN-1:0];
    quo_s = {quo_q[XLEN-2:0], ge};
    q_fin = qneg_q ? -quo_s : quo_s;
    r_fin = rneg_q ? -rem_s : rem_s;
    fin   = rsel_q ? r_fin : q_fin;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rsel_d   = rsel_q;
    w_d      = w_q;
    unique case (state_q)
      IDLE: begin
        if (io.div_valid && !io.flush) begin
          rsel_d = io.div_rem;
          w_d    = io.div_is_w;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (dz || ovf) begin
            state_d  = DONE;
            result_d = io.div_is_w
                     ? {{32{fast[31]}}, fast[31:0]}
                     : fast;
          end else begin
            state_d = BUSY;
            cnt_d   = io.div_is_w ? 7'd32 : 7'd64;
            rem_d   = '0;
            dvs_d   = b_mag;
            // W magnitudes are left-aligned so the MSB feed is fixed
            quo_d   = io.div_is_w ? {a_mag[31:0], 32'b0} : a_mag;
          end
        end
      end
      BUSY: begin
        rem_d = rem_s;
        quo_d = quo_s;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d  = DONE;
          result_d = w_q ? {{32{fin[31]}}, fin[31:0]} : fin;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (io.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rsel_q   <= 1'b0;
      w_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rsel_q   <= rsel_d;
      w_q      <= w_d;
    end
  end
endmodule

// File: tb/tb_ysyx_220066_divider.sv
// Directed-vector bench for ysyx_220066_divider.
// Latency is counted in edges after the accept edge.
module tb_ysyx_220066_divider;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ysyx_220066_divider_if #(.XLEN(64)) dif ();

  ysyx_220066_divider #(.XLEN(64)) dut (
    .clk(clk),
    .rst(rst),
    .io (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(
    input  logic        s,
    input  logic        w,
    input  logic        r,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] res,
    output int          lat
  );
    @(negedge clk);
    dif.div_signed = s;
    dif.div_is_w   = w;
    dif.div_rem    = r;
    dif.dividend   = a;
    dif.divisor    = b;
    dif.div_valid  = 1'b1;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    lat = 0;
    while (!dif.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = dif.result;
  endtask

  task automatic consume();
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (dif.div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", dif.div_ready);
    end
    checks++;
    if (dif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", dif.out_valid);
    end
    checks++;
    if (dif.result !== 64'h0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", dif.result);
    end
  endtask

  task automatic test_divu();
    logic [63:0] res;
    int lat;
    run_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7, res, lat);
    checks++;
    if (lat !== 64) begin
      errors++;
      $display("FAIL divu_lat got %0d want 64", lat);
    end
    checks++;
    if (res !== 64'd14) begin
      errors++;
      $display("FAIL divu_q got %h want 14", res);
    end
    consume();
    run_op(1'b0, 1'b0, 1'b1, 64'd100, 64'd7, res, lat);
    checks++;
    if (res !== 64'd2) begin
      errors++;
      $display("FAIL remu_r got %h want 2", res);
    end
    consume();
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b0, 1'b0, -64'sd7, 64'd2, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg got %h want fffffffffffffffd", res);
    end
    consume();
    run_op(1'b1, 1'b0, 1'b1, -64'sd7, 64'd2, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL rem_neg got %h want ffffffffffffffff", res);
    end
    consume();
    run_op(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           res, lat);
    checks++;
    if (res !== 64'd1) begin
      errors++;
      $display("FAIL remu_big got %h want 1", res);
    end
    consume();
  endtask

  task automatic test_word();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 0) begin
      errors++;
      $display("FAIL divw_ovf got %h lat %0d want ffffffff80000000 lat 0",
               res, lat);
    end
    consume();
    run_op(1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    checks++;
    if (res !== 64'h0) begin
      errors++;
      $display("FAIL remw_ovf got %h want 0", res);
    end
    consume();
    run_op(1'b0, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1,
           res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 32) begin
      errors++;
      $display("FAIL divuw got %h lat %0d want ffffffffffffffff lat 32",
               res, lat);
    end
    consume();
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int lat;
    run_op(1'b1, 1'b0, 1'b0, 64'd5, 64'd0, res, lat);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 0) begin
      errors++;
      $display("FAIL div_z got %h lat %0d want ffffffffffffffff lat 0",
               res, lat);
    end
    consume();
    run_op(1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, res, lat);
    checks++;
    if (res !== 64'h1234 || lat !== 0) begin
      errors++;
      $display("FAIL remu_z got %h lat %0d want 1234 lat 0", res, lat);
    end
    consume();
    run_op(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0009, 64'd0,
           res, lat);
    checks++;
    if (res !== 64'd9 || lat !== 0) begin
      errors++;
      $display("FAIL remw_z got %h lat %0d want 9 lat 0", res, lat);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    int lat;
    run_op(1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, res, lat);
    checks++;
    if (res !== 64'd100) begin
      errors++;
      $display("FAIL bp_q got %h want 100", res);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dif.out_valid !== 1'b1 || dif.result !== 64'd100 ||
          dif.div_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v%b r%h rdy%b want v1 r100 rdy0",
                 dif.out_valid, dif.result, dif.div_ready);
      end
    end
    consume();
    checks++;
    if (dif.div_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy%b v%b want rdy1 v0",
               dif.div_ready, dif.out_valid);
    end
    run_op(1'b0, 1'b0, 1'b0, 64'd9, 64'd3, res, lat);
    checks++;
    if (res !== 64'd3) begin
      errors++;
      $display("FAIL bp_next got %h want 3", res);
    end
    consume();
  endtask

  task automatic test_flush_reset();
    int seen;
    @(negedge clk);
    dif.div_signed = 1'b0;
    dif.div_is_w   = 1'b0;
    dif.div_rem    = 1'b0;
    dif.dividend   = 64'd100;
    dif.divisor    = 64'd7;
    dif.div_valid  = 1'b1;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    // a zero divisor would reach DONE at once if wrongly accepted
    dif.divisor   = 64'd0;
    dif.div_valid = 1'b1;
    dif.flush     = 1'b1;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    dif.flush     = 1'b0;
    checks++;
    if (dif.div_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got rdy%b v%b want rdy1 v0",
               dif.div_ready, dif.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (dif.out_valid || !dif.div_ready) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_quiet got %0d busy cycles want 0", seen);
    end
    @(negedge clk);
    dif.divisor   = 64'd7;
    dif.div_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.div_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (dif.div_ready !== 1'b1 || dif.out_valid !== 1'b0 ||
        dif.result !== 64'h0) begin
      errors++;
      $display("FAIL rst_busy got rdy%b v%b r%h want rdy1 v0 r0",
               dif.div_ready, dif.out_valid, dif.result);
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (dif.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_quiet got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    dif.flush      = 1'b0;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_is_w   = 1'b0;
    dif.div_rem    = 1'b0;
    dif.dividend   = '0;
    dif.divisor    = '0;
    dif.out_ready  = 1'b0;
    test_reset();
    test_divu();
    test_signed();
    test_word();
    test_div_zero();
    test_backpressure();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_220066_divider.md
Name: ysyx_220066_divider

Overview:
- Multi-cycle RV64M divide/remainder unit; responder to the EX stage for DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW.
- EX issues a request, stalls the pipeline until the result is returned, then forwards it as the ALU result.
- Radix-2 restoring shift-subtract: one quotient bit per cycle. Divide-by-zero and signed overflow complete on a fast path.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  cancel any in-flight or pending operation.
- div_valid  input  1  request valid from EX.
- div_ready  output  1  unit idle, can accept a request.
- div_signed  input  1  1 = DIV/REM family, 0 = DIVU/REMU family.
- div_is_w  input  1  32-bit (W) operation.
- div_rem  input  1  1 = return remainder, 0 = return quotient.
- dividend  input  64  rs1 value.
- divisor  input  64  rs2 value.
- out_valid  output  1  result valid.
- out_ready  input  1  EX consumes the result.
- result  output  64  quotient or remainder.

Behaviour:
- One clock (clk); synchronous active-high reset (rst). Everything is registered on the rising edge of clk.
- Reset: state=IDLE; out_valid=0; result=0; internal registers 0. div_ready=1 from the first cycle after reset.
- States: IDLE, BUSY, DONE. div_ready = (state==IDLE), combinational.
- Accept: at an edge with div_valid && div_ready && !flush, latch the operation fields.
  - W operands: low 32 bits, sign-extended if div_signed, else zero-extended.
  - Width N = 32 for W, 64 otherwise.
  - Signed: divide magnitudes; quotient negated if operand signs differ; remainder takes the dividend's sign.
- Fast path, decided at the accept edge, next state DONE (out_valid high one edge after accept):
  - divisor==0: quotient = all ones at width N; remainder = dividend at width N.
  - Signed and dividend = most-negative(N) and divisor = -1: quotient = dividend; remainder = 0.
- Normal path: next state BUSY, counter=N. Each BUSY edge does one shift-subtract step and decrements the counter. The edge that takes the counter 1->0 writes result and enters DONE. out_valid is first high N edges after the accept edge: 64 cycles, or 32 for W.
- W results: 32-bit value sign-extended to 64, including DIVUW/REMUW.
- DONE: out_valid=1; result stable while out_ready=0 (backpressure, unbounded hold).
  - out_valid && out_ready at an edge: next state IDLE, out_valid=0.
  - No new accept in the same cycle (div_ready=0 in DONE).
- flush (any state): next state IDLE, out_valid=0, counter cleared. result may hold its stale value.
  - flush beats div_valid in the same cycle: no accept.
  - flush beats out_ready in DONE: result is discarded.
- rst beats flush and all else; reset mid-BUSY aborts the operation with no output.
- Inputs are ignored outside the accept edge; operand changes during BUSY have no effect.

Test Plan:
- DIVU 100/7, DIV_rem=0: out_valid exactly 64 edges after accept, result=14. Repeat with div_rem=1 -> 2.
- DIV -7/2 -> 0xFFFFFFFFFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFFFFFFFFFF (-1); REMU 0xFFFFFFFFFFFFFFF9 / 2 -> 1.
- DIVW 0x0000000080000000 / 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFF80000000, one edge after accept; REMW same operands -> 0. DIVUW 0xFFFFFFFF/1 -> 0xFFFFFFFFFFFFFFFF after 32 edges.
- Divisor 0: DIV 5/0 -> 0xFFFFFFFFFFFFFFFF; REMU 0x1234/0 -> 0x1234; REMW 0xFFFFFFFF00000009/0 -> 9. All one edge after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, div_ready=0. Raise out_ready -> IDLE next edge, then a new request is accepted.
- Flush at BUSY cycle 20 with div_valid=1 -> IDLE next edge, no out_valid, no accept that cycle. rst asserted mid-BUSY -> IDLE, out_valid=0, result=0.
